wb_reg_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the FPGA register-bank slave port between the AHB-to-FPGA bridge (master 0) and an on-fabric sequencer (master 1). It grants one master at a time with round-robin fairness. It forwards the granted master's cycle to the register slave and routes the slave's acknowledge and read data back. It sits between the bridge/sequencer and the register module; an optional watchdog terminates cycles the slave never acknowledges.

---
 rtl/wb_reg_arbiter_pkg.sv | 19 +
 rtl/wb_reg_arbiter_wdog.sv | 51 +++++
 rtl/wb_reg_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_reg_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_reg_arbiter_pkg.sv
// wb_reg_arbiter_pkg
// Shared definitions for the two-master Wishbone register arbiter:
//   - arb_state_t : arbiter state encoding (IDLE / GRANT0 / GRANT1)
//   - MASTER0_IDX / MASTER1_IDX : values held in the last_grant register
//   - TCNT_W : width of the saturating watchdog event counter
package wb_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10
  } arb_state_t;

  localparam logic MASTER0_IDX = 1'b0;
  localparam logic MASTER1_IDX = 1'b1;

  localparam int TCNT_W = 8;

endpackage

// File: rtl/wb_reg_arbiter_wdog.sv
// wb_reg_arbiter_wdog
// Grant watchdog: counts cycles spent in a grant state and flags expiry when
// TIMEOUT_CYCLES cycles have passed without a slave acknowledge. Also keeps a
// saturating count of expiries. Only instantiated when
// WB_REG_ARBITER_TIMEOUT_EN is defined.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   grant      : arbiter is in a grant state
//   ack        : slave acknowledge (an ACK in the expiry cycle wins)
//   expire     : combinational, high for the one cycle the watchdog terminates
//   event_cnt  : saturating count of terminations
module wb_reg_arbiter_wdog
  import wb_reg_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant,
  input  logic              ack,
  output logic              expire,
  output logic [TCNT_W-1:0] event_cnt
);

  logic [7:0] cycle_cnt;

  // Count is 0 in the first grant cycle, so expiry lands TIMEOUT_CYCLES
  // cycles after the grant starts.
  assign expire = grant && !ack && (cycle_cnt == 8'(TIMEOUT_CYCLES));

  // Every grant is preceded by at least one IDLE cycle, so clearing while
  // not granted is the same as clearing on grant entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (!grant) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_cnt <= '0;
    end else if (expire && (event_cnt != {TCNT_W{1'b1}})) begin
      event_cnt <= event_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_reg_arbiter.sv
// wb_reg_arbiter
// Two-master round-robin Wishbone arbiter in front of the FPGA register bank.
// Master 0 is the AHB-to-FPGA bridge, master 1 the on-fabric sequencer.
// The granted master's cycle is passed combinationally to the slave; slave
// ACK/read data are routed back to the granted master only.
// Optional watchdog: define WB_REG_ARBITER_TIMEOUT_EN to terminate cycles the
// slave never acknowledges (TIMEOUT_o / TIMEOUT_CNT_o); otherwise both are 0.
// Ports:
//   WBs_CLK_i, WBs_RST_i           : clock, asynchronous active-high reset
//   Mx_ADR/CYC/STB/WE/BYTE_STB/DAT_i: master x request signals
//   Mx_DAT_o, Mx_ACK_o             : read data / acknowledge to master x
//   S_*_o                          : slave-side copy of the granted request
//   S_DAT_i, S_ACK_i               : slave read data / acknowledge
//   ARB_BUSY_o                     : high in any grant state
//   TIMEOUT_o, TIMEOUT_CNT_o       : watchdog termination pulse / count
module wb_reg_arbiter
  import wb_reg_arbiter_pkg::*;
#(
  parameter int                    ADDRWIDTH         = 7,
  parameter int                    DATAWIDTH         = 32,
  parameter int                    TIMEOUT_CYCLES    = 16,
  parameter logic [DATAWIDTH-1:0]  TIMEOUT_DAT_VALUE = 32'hFAB_DEF_AC
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,

  input  logic [ADDRWIDTH-1:0] M0_ADR_i,
  input  logic                 M0_CYC_i,
  input  logic                 M0_STB_i,
  input  logic                 M0_WE_i,
  input  logic [3:0]           M0_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] M0_DAT_i,
  output logic [DATAWIDTH-1:0] M0_DAT_o,
  output logic                 M0_ACK_o,

  input  logic [ADDRWIDTH-1:0] M1_ADR_i,
  input  logic                 M1_CYC_i,
  input  logic                 M1_STB_i,
  input  logic                 M1_WE_i,
  input  logic [3:0]           M1_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] M1_DAT_i,
  output logic [DATAWIDTH-1:0] M1_DAT_o,
  output logic                 M1_ACK_o,

  output logic [ADDRWIDTH-1:0] S_ADR_o,
  output logic                 S_CYC_o,
  output logic                 S_STB_o,
  output logic                 S_WE_o,
  output logic [3:0]           S_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] S_DAT_o,
  input  logic [DATAWIDTH-1:0] S_DAT_i,
  input  logic                 S_ACK_i,

  output logic                 ARB_BUSY_o,
  output logic                 TIMEOUT_o,
  output logic [TCNT_W-1:0]    TIMEOUT_CNT_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_reg_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  arb_state_t state;
  logic       last_grant;
  logic       expire;
  logic       req0;
  logic       req1;

  assign req0 = M0_CYC_i & M0_STB_i;
  assign req1 = M1_CYC_i & M1_STB_i;

  // state is a flop with async reset, so S_CYC_o drops as soon as reset hits.
  assign ARB_BUSY_o = (state != ST_IDLE);

`ifdef WB_REG_ARBITER_TIMEOUT_EN
  wb_reg_arbiter_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk       (WBs_CLK_i),
    .rst       (WBs_RST_i),
    .grant     (ARB_BUSY_o),
    .ack       (S_ACK_i),
    .expire    (expire),
    .event_cnt (TIMEOUT_CNT_o)
  );
  assign TIMEOUT_o = expire;
`else
  assign expire        = 1'b0;
  assign TIMEOUT_o     = 1'b0;
  assign TIMEOUT_CNT_o = '0;
`endif

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state      <= ST_IDLE;
      last_grant <= MASTER1_IDX;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 && req1) begin
            state <= (last_grant == MASTER1_IDX) ? ST_GRANT0 : ST_GRANT1;
          end else if (req0) begin
            state <= ST_GRANT0;
          end else if (req1) begin
            state <= ST_GRANT1;
          end
        end
        ST_GRANT0: begin
          if (S_ACK_i || expire || !M0_CYC_i) begin
            state      <= ST_IDLE;
            last_grant <= MASTER0_IDX;
          end
        end
        ST_GRANT1: begin
          if (S_ACK_i || expire || !M1_CYC_i) begin
            state      <= ST_IDLE;
            last_grant <= MASTER1_IDX;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Grant mux. On expiry the slave strobe is withdrawn and the master gets a
  // synthetic ACK carrying TIMEOUT_DAT_VALUE.
  always_comb begin
    S_ADR_o      = '0;
    S_CYC_o      = 1'b0;
    S_STB_o      = 1'b0;
    S_WE_o       = 1'b0;
    S_BYTE_STB_o = '0;
    S_DAT_o      = '0;
    M0_ACK_o     = 1'b0;
    M0_DAT_o     = '0;
    M1_ACK_o     = 1'b0;
    M1_DAT_o     = '0;
    case (state)
      ST_GRANT0: begin
        S_ADR_o      = M0_ADR_i;
        S_CYC_o      = M0_CYC_i & ~expire;
        S_STB_o      = M0_STB_i & ~expire;
        S_WE_o       = M0_WE_i;
        S_BYTE_STB_o = M0_BYTE_STB_i;
        S_DAT_o      = M0_DAT_i;
        M0_ACK_o     = S_ACK_i | expire;
        M0_DAT_o     = expire ? TIMEOUT_DAT_VALUE : S_DAT_i;
      end
      ST_GRANT1: begin
        S_ADR_o      = M1_ADR_i;
        S_CYC_o      = M1_CYC_i & ~expire;
        S_STB_o      = M1_STB_i & ~expire;
        S_WE_o       = M1_WE_i;
        S_BYTE_STB_o = M1_BYTE_STB_i;
        S_DAT_o      = M1_DAT_i;
        M1_ACK_o     = S_ACK_i | expire;
        M1_DAT_o     = expire ? TIMEOUT_DAT_VALUE : S_DAT_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_reg_arbiter.sv
// tb_wb_reg_arbiter
// Directed bench for wb_reg_arbiter with a registered one-cycle-ACK slave
// model. Inputs change and outputs are sampled on the falling clock edge.
// Follows WB_REG_ARBITER_TIMEOUT_EN the same way the RTL does.
module tb_wb_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [6:0]  m0_adr = '0, m1_adr = '0;
  logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [3:0]  m0_bs = '0, m1_bs = '0;
  logic [31:0] m0_wdat = '0, m1_wdat = '0;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack;

  logic [6:0]  s_adr;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_bs;
  logic [31:0] s_wdat;
  logic [31:0] s_rdat;
  logic        s_ack;

  logic        busy, tmo;
  logic [7:0]  tmo_cnt;

  logic        slave_mute = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_reg_arbiter dut (
    .WBs_CLK_i     (clk),
    .WBs_RST_i     (rst),
    .M0_ADR_i      (m0_adr),
    .M0_CYC_i      (m0_cyc),
    .M0_STB_i      (m0_stb),
    .M0_WE_i       (m0_we),
    .M0_BYTE_STB_i (m0_bs),
    .M0_DAT_i      (m0_wdat),
    .M0_DAT_o      (m0_rdat),
    .M0_ACK_o      (m0_ack),
    .M1_ADR_i      (m1_adr),
    .M1_CYC_i      (m1_cyc),
    .M1_STB_i      (m1_stb),
    .M1_WE_i       (m1_we),
    .M1_BYTE_STB_i (m1_bs),
    .M1_DAT_i      (m1_wdat),
    .M1_DAT_o      (m1_rdat),
    .M1_ACK_o      (m1_ack),
    .S_ADR_o       (s_adr),
    .S_CYC_o       (s_cyc),
    .S_STB_o       (s_stb),
    .S_WE_o        (s_we),
    .S_BYTE_STB_o  (s_bs),
    .S_DAT_o       (s_wdat),
    .S_DAT_i       (s_rdat),
    .S_ACK_i       (s_ack),
    .ARB_BUSY_o    (busy),
    .TIMEOUT_o     (tmo),
    .TIMEOUT_CNT_o (tmo_cnt)
  );

  function automatic logic [31:0] reg_value(input logic [6:0] adr);
    if (adr == 7'h0) return 32'h0055_C332;
    return {4{1'b0, adr}};
  endfunction

  // Registered slave: one-cycle ACK pulse the cycle after a strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack  <= 1'b0;
      s_rdat <= '0;
    end else begin
      s_ack  <= s_cyc & s_stb & ~s_ack & ~slave_mute;
      s_rdat <= reg_value(s_adr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "bench time limit");
  end

  initial begin
    logic saw_ack;
    logic busy_held;

    // Reset state
    step(); step();
    check("rst_s_cyc",   32'(s_cyc),   32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_m0_ack",  32'(m0_ack),  32'd0);
    check("rst_tmo_cnt", 32'(tmo_cnt), 32'd0);
    rst = 1'b0;
    step();

    // Contested requests from reset: M0, M1, M0, M1
    m0_adr = 7'h1; m1_adr = 7'h2;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int r = 0; r < 4; r++) begin
      step();
      check($sformatf("rr%0d_adr", r), 32'(s_adr), (r % 2 == 0) ? 32'h1 : 32'h2);
      step();
      check($sformatf("rr%0d_m0_ack", r), 32'(m0_ack), (r % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_m1_ack", r), 32'(m1_ack), (r % 2 == 0) ? 32'd0 : 32'd1);
      step();
      check($sformatf("rr%0d_idle", r), 32'(busy), 32'd0);
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();

    // M0 read of adr 0 alone
    m0_adr = 7'h0; m0_we = 1'b0; m0_bs = 4'hF;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    check("rd_s_stb", 32'(s_stb), 32'd1);
    check("rd_m0_ack_early", 32'(m0_ack), 32'd0);
    step();
    check("rd_m0_ack", 32'(m0_ack), 32'd1);
    check("rd_m0_dat", m0_rdat, 32'h0055_C332);
    check("rd_m1_ack", 32'(m1_ack), 32'd0);
    check("rd_m1_dat", m1_rdat, 32'd0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    check("rd_idle", 32'(busy), 32'd0);
    check("rd_idle_s_cyc", 32'(s_cyc), 32'd0);

    // M1 write 0xA5 to adr 3, byte strobe 1
    m1_adr = 7'h3; m1_we = 1'b1; m1_bs = 4'h1; m1_wdat = 32'h0000_00A5;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    check("wr_s_dat", s_wdat, 32'h0000_00A5);
    check("wr_s_we",  32'(s_we), 32'd1);
    check("wr_s_bs",  32'(s_bs), 32'h1);
    check("wr_s_adr", 32'(s_adr), 32'h3);
    step();
    check("wr_m1_ack", 32'(m1_ack), 32'd1);
    check("wr_m0_ack", 32'(m0_ack), 32'd0);
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    step();
    check("wr_m1_ack_pulse", 32'(m1_ack), 32'd0);

    // M1 abort in GRANT1 with M0 pending
    slave_mute = 1'b1;
    m1_adr = 7'h2; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    check("ab_grant1", 32'(s_adr), 32'h2);
    m0_adr = 7'h1; m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    check("ab_idle", 32'(busy), 32'd0);
    check("ab_m1_ack", 32'(m1_ack), 32'd0);
    step();
    check("ab_grant0_busy", 32'(busy), 32'd1);
    check("ab_grant0_adr", 32'(s_adr), 32'h1);

    // Slave never acknowledges M0 (grant started one edge ago)
    saw_ack = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      if (m0_ack) saw_ack = 1'b1;
    end
    check("to_no_early_ack", 32'(saw_ack), 32'd0);
    step();
`ifdef WB_REG_ARBITER_TIMEOUT_EN
    check("to_m0_ack", 32'(m0_ack), 32'd1);
    check("to_m0_dat", m0_rdat, 32'hFABD_EFAC);
    check("to_pulse",  32'(tmo), 32'd1);
    check("to_s_cyc",  32'(s_cyc), 32'd0);
    check("to_s_stb",  32'(s_stb), 32'd0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    check("to_pulse_end", 32'(tmo), 32'd0);
    check("to_cnt", 32'(tmo_cnt), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
`else
    check("nto_m0_ack", 32'(m0_ack), 32'd0);
    check("nto_pulse", 32'(tmo), 32'd0);
    busy_held = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (!busy || m0_ack) busy_held = 1'b0;
    end
    check("nto_grant_held", 32'(busy_held), 32'd1);
    check("nto_cnt", 32'(tmo_cnt), 32'd0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    check("nto_abort_idle", 32'(busy), 32'd0);
`endif

    // Reset asserted mid-GRANT0
    m0_adr = 7'h1; m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    check("rg_s_cyc", 32'(s_cyc), 32'd1);
    #2 rst = 1'b1;
    #1 check("rg_async_s_cyc", 32'(s_cyc), 32'd0);
    check("rg_async_busy", 32'(busy), 32'd0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    rst = 1'b0;
    slave_mute = 1'b0;
    check("rg_tmo_cnt", 32'(tmo_cnt), 32'd0);
    step();
    m0_adr = 7'h1; m1_adr = 7'h2;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    check("rg_first_grant", 32'(s_adr), 32'h1);
    step();
    check("rg_m0_ack", 32'(m0_ack), 32'd1);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
